// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, ALU operation
// codes, opcode/funct constants and datapath mux select codes.
package mips_multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RST_HOLD = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_RTYPE_EX = 4'd3,
        S_RTYPE_WB = 4'd4,
        S_IMM_EX   = 4'd5,
        S_IMM_WB   = 4'd6,
        S_MEMADDR  = 4'd7,
        S_MEMREAD  = 4'd8,
        S_MEMWRITE = 4'd9,
        S_MEM_WB   = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_JR       = 4'd13
    } state_t;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_NOR = 4'd2;
    localparam logic [3:0] ALU_ADD = 4'd3;
    localparam logic [3:0] ALU_SUB = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_LUI = 4'd7;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;

    localparam logic [1:0] SRCB_B       = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    localparam logic [1:0] PCS_ALURES = 2'd0;
    localparam logic [1:0] PCS_ALUOUT = 2'd1;
    localparam logic [1:0] PCS_JUMP   = 2'd2;
    localparam logic [1:0] PCS_REG    = 2'd3;

    localparam logic [1:0] RD_RT = 2'd0;
    localparam logic [1:0] RD_RD = 2'd1;
    localparam logic [1:0] RD_RA = 2'd2;

    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_PC     = 2'd2;

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_RTYPE: return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR,
                                        FN_SLL, FN_SRL, FN_JR};
            OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_LUI,
            OP_LW, OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_alu_op_decode.sv
// Combinational ALU operation and immediate-extension select, derived from the
// controller state and the instruction's opcode/funct fields.
module mips_alu_op_decode
    import mips_multicycle_ctrl_pkg::*;
(
    input  logic [3:0] i_state,
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output logic [3:0] o_alu_op,
    output logic       o_ext_op
);

    state_t w_state;
    assign w_state = state_t'(i_state);

    always_comb begin
        o_alu_op = ALU_AND;
        o_ext_op = 1'b0;
        case (w_state)
            S_RST_HOLD, S_FETCH, S_DECODE, S_MEMADDR: o_alu_op = ALU_ADD;
            S_BRANCH: o_alu_op = ALU_SUB;
            S_RTYPE_EX: begin
                case (i_funct)
                    FN_ADD:  o_alu_op = ALU_ADD;
                    FN_SUB:  o_alu_op = ALU_SUB;
                    FN_AND:  o_alu_op = ALU_AND;
                    FN_OR:   o_alu_op = ALU_OR;
                    FN_NOR:  o_alu_op = ALU_NOR;
                    FN_SLL:  o_alu_op = ALU_SLL;
                    FN_SRL:  o_alu_op = ALU_SRL;
                    default: o_alu_op = ALU_ADD;
                endcase
            end
            // Logical immediates and lui take the zero-extended immediate
            S_IMM_EX: begin
                case (i_opcode)
                    OP_ANDI: begin o_alu_op = ALU_AND; o_ext_op = 1'b1; end
                    OP_ORI:  begin o_alu_op = ALU_OR;  o_ext_op = 1'b1; end
                    OP_LUI:  begin o_alu_op = ALU_LUI; o_ext_op = 1'b1; end
                    default: o_alu_op = ALU_ADD;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences FETCH..WRITEBACK, stalls on MemReady and
// decodes datapath enables/selects from the state register.
module mips_multicycle_ctrl
    import mips_multicycle_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       MemReady,
    output logic [3:0] ALUOperation,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ExtOp,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic [1:0] PCSource,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic       IllegalInstr
);

    state_t r_state;
    logic   w_illegal;

    assign w_illegal = !is_legal(Opcode, Funct);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_RST_HOLD;
        end else begin
            case (r_state)
                S_RST_HOLD: r_state <= S_FETCH;
                S_FETCH:    if (MemReady) r_state <= S_DECODE;
                S_DECODE: begin
                    if (w_illegal) begin
                        r_state <= S_FETCH;
                    end else begin
                        case (Opcode)
                            OP_RTYPE:       r_state <= (Funct == FN_JR) ? S_JR : S_RTYPE_EX;
                            OP_LW, OP_SW:   r_state <= S_MEMADDR;
                            OP_BEQ, OP_BNE: r_state <= S_BRANCH;
                            OP_J, OP_JAL:   r_state <= S_JUMP;
                            default:        r_state <= S_IMM_EX;
                        endcase
                    end
                end
                S_RTYPE_EX: r_state <= S_RTYPE_WB;
                S_IMM_EX:   r_state <= S_IMM_WB;
                S_MEMADDR:  r_state <= (Opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  if (MemReady) r_state <= S_MEM_WB;
                S_MEMWRITE: if (MemReady) r_state <= S_FETCH;
                default:    r_state <= S_FETCH;
            endcase
        end
    end

    mips_alu_op_decode u_alu_op_decode (
        .i_state  (r_state),
        .i_opcode (Opcode),
        .i_funct  (Funct),
        .o_alu_op (ALUOperation),
        .o_ext_op (ExtOp)
    );

    always_comb begin
        ALUSrcA      = 1'b0;
        ALUSrcB      = SRCB_B;
        IorD         = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        PCWrite      = 1'b0;
        PCSource     = PCS_ALURES;
        RegWrite     = 1'b0;
        RegDst       = RD_RT;
        MemtoReg     = M2R_ALUOUT;
        IllegalInstr = 1'b0;
        case (r_state)
            // IR and PC only load once memory has delivered the instruction
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            S_DECODE: begin
                ALUSrcB      = SRCB_IMM_SH2;
                IllegalInstr = w_illegal;
            end
            S_RTYPE_EX: ALUSrcA = 1'b1;
            S_RTYPE_WB: begin
                RegDst   = RD_RD;
                RegWrite = 1'b1;
            end
            S_IMM_EX, S_MEMADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_IMM_WB: RegWrite = 1'b1;
            S_MEMREAD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            S_MEMWRITE: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_MEM_WB: begin
                MemtoReg = M2R_MDR;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                PCSource = PCS_ALUOUT;
                PCWrite  = (Opcode == OP_BEQ) ? Zero : !Zero;
            end
            S_JUMP: begin
                PCSource = PCS_JUMP;
                PCWrite  = 1'b1;
                if (Opcode == OP_JAL) begin
                    RegDst   = RD_RA;
                    MemtoReg = M2R_PC;
                    RegWrite = 1'b1;
                end
            end
            S_JR: begin
                PCSource = PCS_REG;
                PCWrite  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: per-instruction expected cycle schedules built
// from the instruction-level behaviour, applied from a table and at random.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Opcode, Funct;
    logic       Zero, MemReady;
    logic [3:0] ALUOperation;
    logic       ALUSrcA, ExtOp, IorD, MemRead, MemWrite, IRWrite, PCWrite, RegWrite, IllegalInstr;
    logic [1:0] ALUSrcB, PCSource, RegDst, MemtoReg;

    always #5 clk = ~clk;

    mips_multicycle_ctrl dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
        .MemReady(MemReady), .ALUOperation(ALUOperation), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ExtOp(ExtOp), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .PCSource(PCSource), .RegWrite(RegWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .IllegalInstr(IllegalInstr)
    );

    typedef struct packed {
        logic [3:0] alu;
        logic       srca;
        logic [1:0] srcb;
        logic       ext, iord, mrd, mwr, irw, pcw;
        logic [1:0] pcsrc;
        logic       rw;
        logic [1:0] regdst, m2r;
        logic       ill;
    } outv_t;

    typedef struct packed {
        logic  mr;
        outv_t exp;
    } step_t;

    typedef struct {
        logic [5:0] op, fn;
        logic       z;
        int         fst, mst;
        logic       ill;
        logic [3:0] alu;
        logic       ext;
        string      nm;
    } vec_t;

    outv_t  w_obs;
    assign w_obs = {ALUOperation, ALUSrcA, ALUSrcB, ExtOp, IorD, MemRead, MemWrite,
                    IRWrite, PCWrite, PCSource, RegWrite, RegDst, MemtoReg, IllegalInstr};

    step_t q[$];
    vec_t  tab[$];
    int    checks = 0;
    int    failures = 0;

    localparam logic [3:0] A_AND = 4'd0, A_OR = 4'd1, A_NOR = 4'd2, A_ADD = 4'd3;
    localparam logic [3:0] A_SUB = 4'd4, A_SLL = 4'd5, A_SRL = 4'd6, A_LUI = 4'd7;

    function automatic logic legal(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h00, 6'h02, 6'h08};
        return op inside {6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};
    endfunction

    function automatic logic [3:0] rmap(input logic [5:0] fn);
        case (fn)
            6'h20: return A_ADD;
            6'h22: return A_SUB;
            6'h24: return A_AND;
            6'h25: return A_OR;
            6'h27: return A_NOR;
            6'h00: return A_SLL;
            default: return A_SRL;
        endcase
    endfunction

    function automatic outv_t mk(input logic [3:0] alu, input logic sa, input logic [1:0] sb);
        outv_t v = '0;
        v.alu = alu; v.srca = sa; v.srcb = sb;
        return v;
    endfunction

    function automatic outv_t v_fetch(input logic r);
        outv_t v = mk(A_ADD, 1'b0, 2'd1);
        v.mrd = 1'b1; v.irw = r; v.pcw = r;
        return v;
    endfunction

    function automatic outv_t v_rst();
        outv_t v = '0;
        v.alu = A_ADD;
        return v;
    endfunction

    task automatic push(input outv_t v, input logic mr);
        step_t s;
        s.mr = mr; s.exp = v;
        q.push_back(s);
    endtask

    task automatic push_any(input outv_t v);
        push(v, 1'($urandom_range(0, 1)));
    endtask

    // Expected cycle-by-cycle schedule for one instruction, fetch included
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                         input int fst, input int mst);
        outv_t v;
        q.delete();
        for (int i = 0; i <= fst; i++) push(v_fetch(i == fst), i == fst);
        v = mk(A_ADD, 1'b0, 2'd3);
        v.ill = !legal(op, fn);
        push_any(v);
        if (v.ill) return;
        if (op == 6'h00 && fn == 6'h08) begin
            v = '0; v.pcsrc = 2'd3; v.pcw = 1'b1; push_any(v);
        end else if (op == 6'h00) begin
            push_any(mk(rmap(fn), 1'b1, 2'd0));
            v = '0; v.regdst = 2'd1; v.rw = 1'b1; push_any(v);
        end else if (op == 6'h23 || op == 6'h2B) begin
            push_any(mk(A_ADD, 1'b1, 2'd2));
            v = '0; v.iord = 1'b1;
            if (op == 6'h23) v.mrd = 1'b1; else v.mwr = 1'b1;
            for (int i = 0; i < mst; i++) push(v, 1'b0);
            push(v, 1'b1);
            if (op == 6'h23) begin
                v = '0; v.m2r = 2'd1; v.rw = 1'b1; push_any(v);
            end
        end else if (op == 6'h04 || op == 6'h05) begin
            v = mk(A_SUB, 1'b1, 2'd0);
            v.pcsrc = 2'd1;
            v.pcw = (op == 6'h04) ? z : !z;
            push_any(v);
        end else if (op == 6'h02 || op == 6'h03) begin
            v = '0; v.pcsrc = 2'd2; v.pcw = 1'b1;
            if (op == 6'h03) begin v.regdst = 2'd2; v.m2r = 2'd2; v.rw = 1'b1; end
            push_any(v);
        end else begin
            case (op)
                6'h08:   v = mk(A_ADD, 1'b1, 2'd2);
                6'h0C:   begin v = mk(A_AND, 1'b1, 2'd2); v.ext = 1'b1; end
                6'h0D:   begin v = mk(A_OR,  1'b1, 2'd2); v.ext = 1'b1; end
                default: begin v = mk(A_LUI, 1'b1, 2'd2); v.ext = 1'b1; end
            endcase
            push_any(v);
            v = '0; v.rw = 1'b1; push_any(v);
        end
    endtask

    task automatic step(input logic rn, input logic mr, input outv_t exp,
                        input string nm, output outv_t obs);
        @(negedge clk);
        reset = rn;
        MemReady = mr;
        #1;
        obs = w_obs;
        checks++;
        if (w_obs !== exp) begin
            failures++;
            $display("FAIL %s: outputs got %h expected %h", nm, w_obs, exp);
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int fst, input int mst, input int start, input string nm,
                             output outv_t key_dec, output outv_t key_ex);
        outv_t o;
        Opcode = op; Funct = fn; Zero = z;
        build(op, fn, z, fst, mst);
        key_dec = '0; key_ex = '0;
        for (int i = start; i < q.size(); i++) begin
            step(1'b1, q[i].mr, q[i].exp, nm, o);
            if (i == fst + 1) key_dec = o;
            if (i == fst + 2) key_ex = o;
        end
        @(posedge clk);
        #1;
        checks++;
        if (!(MemRead === 1'b1 && IorD === 1'b0 && ALUSrcB === 2'd1 &&
              RegWrite === 1'b0 && MemWrite === 1'b0)) begin
            failures++;
            $display("FAIL %s_return: MemRead=%b IorD=%b ALUSrcB=%0d RegWrite=%b, need fetch 1/0/1/0",
                     nm, MemRead, IorD, ALUSrcB, RegWrite);
        end
    endtask

    task automatic addv(input logic [5:0] op, input logic [5:0] fn, input logic z,
                        input int fst, input int mst, input logic ill,
                        input logic [3:0] alu, input logic ext, input string nm);
        vec_t t;
        t.op = op; t.fn = fn; t.z = z; t.fst = fst; t.mst = mst;
        t.ill = ill; t.alu = alu; t.ext = ext; t.nm = nm;
        tab.push_back(t);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        outv_t o, kd, ke;
        logic [5:0] ops[13];
        logic [5:0] fns[8];
        ops = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0C,
                6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h3F};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h00, 6'h02, 6'h08};

        addv(6'h00, 6'h20, 1'b0, 0, 0, 1'b0, A_ADD, 1'b0, "add");
        addv(6'h00, 6'h22, 1'b0, 0, 0, 1'b0, A_SUB, 1'b0, "sub");
        addv(6'h00, 6'h24, 1'b0, 1, 0, 1'b0, A_AND, 1'b0, "and");
        addv(6'h00, 6'h25, 1'b0, 0, 0, 1'b0, A_OR,  1'b0, "or");
        addv(6'h00, 6'h27, 1'b0, 0, 0, 1'b0, A_NOR, 1'b0, "nor");
        addv(6'h00, 6'h00, 1'b0, 0, 0, 1'b0, A_SLL, 1'b0, "sll");
        addv(6'h00, 6'h02, 1'b0, 2, 0, 1'b0, A_SRL, 1'b0, "srl");
        addv(6'h00, 6'h08, 1'b0, 0, 0, 1'b0, A_AND, 1'b0, "jr");
        addv(6'h23, 6'h11, 1'b0, 0, 3, 1'b0, A_ADD, 1'b0, "lw_stall3");
        addv(6'h23, 6'h00, 1'b0, 0, 0, 1'b0, A_ADD, 1'b0, "lw");
        addv(6'h2B, 6'h00, 1'b0, 1, 2, 1'b0, A_ADD, 1'b0, "sw");
        addv(6'h04, 6'h00, 1'b1, 0, 0, 1'b0, A_SUB, 1'b0, "beq_z1");
        addv(6'h04, 6'h00, 1'b0, 0, 0, 1'b0, A_SUB, 1'b0, "beq_z0");
        addv(6'h05, 6'h00, 1'b1, 0, 0, 1'b0, A_SUB, 1'b0, "bne_z1");
        addv(6'h05, 6'h00, 1'b0, 0, 0, 1'b0, A_SUB, 1'b0, "bne_z0");
        addv(6'h02, 6'h00, 1'b0, 0, 0, 1'b0, A_AND, 1'b0, "j");
        addv(6'h03, 6'h00, 1'b0, 0, 0, 1'b0, A_AND, 1'b0, "jal");
        addv(6'h08, 6'h00, 1'b0, 0, 0, 1'b0, A_ADD, 1'b0, "addi");
        addv(6'h0C, 6'h00, 1'b0, 0, 0, 1'b0, A_AND, 1'b1, "andi");
        addv(6'h0D, 6'h00, 1'b0, 0, 0, 1'b0, A_OR,  1'b1, "ori");
        addv(6'h0F, 6'h00, 1'b0, 0, 0, 1'b0, A_LUI, 1'b1, "lui");
        addv(6'h3F, 6'h20, 1'b0, 0, 0, 1'b1, A_ADD, 1'b0, "ill_op");
        addv(6'h00, 6'h2A, 1'b0, 0, 0, 1'b1, A_ADD, 1'b0, "ill_fn");

        reset = 1'b0; MemReady = 1'b0; Opcode = 6'h00; Funct = 6'h20; Zero = 1'b0;
        repeat (2) @(posedge clk);
        step(1'b0, 1'b1, v_rst(), "reset_hold", o);
        step(1'b1, 1'b1, v_rst(), "reset_release", o);

        foreach (tab[i]) begin
            run_instr(tab[i].op, tab[i].fn, tab[i].z, tab[i].fst, tab[i].mst, 0, tab[i].nm, kd, ke);
            checks++;
            if (kd.ill !== tab[i].ill) begin
                failures++;
                $display("FAIL %s_illegal: IllegalInstr got %b expected %b", tab[i].nm, kd.ill, tab[i].ill);
            end
            if (!tab[i].ill) begin
                checks++;
                if (ke.alu !== tab[i].alu || ke.ext !== tab[i].ext) begin
                    failures++;
                    $display("FAIL %s_exec: ALUOperation/ExtOp got %0d/%b expected %0d/%b",
                             tab[i].nm, ke.alu, ke.ext, tab[i].alu, tab[i].ext);
                end
            end
        end

        // Reset while lw is stalled in its memory read: abort without any write
        Opcode = 6'h23; Funct = 6'h00; Zero = 1'b0;
        build(6'h23, 6'h00, 1'b0, 0, 2);
        for (int i = 0; i < 4; i++) step(1'b1, q[i].mr, q[i].exp, "rst_lw_pre", o);
        step(1'b0, 1'b0, q[3].exp, "rst_lw_assert", o);
        step(1'b0, 1'b1, v_rst(), "rst_lw_hold1", o);
        step(1'b1, 1'b1, v_rst(), "rst_lw_hold2", o);
        step(1'b1, 1'b1, v_fetch(1'b1), "rst_lw_fetch", o);
        run_instr(6'h23, 6'h00, 1'b0, 0, 0, 1, "rst_lw_resume", kd, ke);

        for (int n = 0; n < 60; n++) begin
            logic [5:0] op, fn;
            int k;
            op = ops[$urandom_range(0, 12)];
            if ($urandom_range(0, 19) == 0) op = 6'($urandom_range(0, 63));
            k = $urandom_range(0, 9);
            fn = (k < 8) ? fns[k] : 6'($urandom_range(0, 63));
            run_instr(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                      $urandom_range(0, 3), 0, "rand", kd, ke);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
